// File: rtl/demux_stream.sv
// 1-to-CHANNELS registered stream demultiplexer with a one-entry buffer per channel.
// Optional broadcast input (in_bcast) is compiled in when DEMUX_BROADCAST_EN is defined.
module demux_stream #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
`ifdef DEMUX_BROADCAST_EN
  input  logic                      in_bcast,
`endif
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      bad_sel
);

  // Handshake: a beat moves on any interface in a cycle where valid && ready
  // at the rising edge; valid never waits on ready, and a raised out_valid
  // holds with stable data until its consumer takes it.

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  localparam logic [SEL_W:0] SEL_LIMIT = CHANNELS[SEL_W:0];

  ch_state_e            state_q [CHANNELS];
  ch_state_e            state_d [CHANNELS];
  logic [WIDTH-1:0]     data_q  [CHANNELS];

  logic [CHANNELS-1:0]  sel_hit;
  logic [CHANNELS-1:0]  ch_ready;
  logic [CHANNELS-1:0]  drain;
  logic [CHANNELS-1:0]  load;
  logic                 sel_in_range;
  logic                 accept;
  logic                 bad_next;
  logic                 bad_sel_q;

  // A channel can take a beat when it is empty or is being drained this cycle.
  always_comb begin
    sel_hit  = '0;
    ch_ready = '0;
    drain    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      sel_hit[k]  = (in_sel == k[SEL_W-1:0]);
      ch_ready[k] = (state_q[k] == CH_EMPTY) || out_ready[k];
      drain[k]    = (state_q[k] == CH_FULL) && out_ready[k];
    end
  end

  assign sel_in_range = ({1'b0, in_sel} < SEL_LIMIT);

`ifdef DEMUX_BROADCAST_EN
  assign in_ready = in_bcast ? (&ch_ready)
                             : (!sel_in_range || (|(sel_hit & ch_ready)));
  assign accept   = in_valid && in_ready;
  assign load     = !accept  ? '0
                  : in_bcast ? {CHANNELS{1'b1}}
                  :            sel_hit;
  assign bad_next = accept && !in_bcast && !sel_in_range;
`else
  assign in_ready = !sel_in_range || (|(sel_hit & ch_ready));
  assign accept   = in_valid && in_ready;
  // sel_hit is all-zero for an out-of-range select, so such beats load nothing.
  assign load     = accept ? sel_hit : '0;
  assign bad_next = accept && !sel_in_range;
`endif

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        CH_EMPTY: if (load[k]) state_d[k] = CH_FULL;
        CH_FULL:  if (drain[k] && !load[k]) state_d[k] = CH_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= CH_EMPTY;
        data_q[k]  <= '0;
      end
      bad_sel_q <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        if (load[k]) data_q[k] <= in_data;
      end
      bad_sel_q <= bad_next;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign out_valid[g]                 = (state_q[g] == CH_FULL);
    assign out_data[g*WIDTH +: WIDTH]   = data_q[g];
  end

  assign bad_sel = bad_sel_q;

endmodule

// File: tb/tb_demux_stream.sv
// Randomized and directed bench for demux_stream (WIDTH=4, CHANNELS=3) against
// a queue-based reference model of per-channel one-entry buffers.
module tb_demux_stream;

  localparam int W  = 4;
  localparam int CH = 3;
  localparam int SW = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0]    in_data   = '0;
  logic [SW-1:0]   in_sel    = '0;
  logic            in_valid  = 1'b0;
  logic            in_ready;
  logic [CH*W-1:0] out_data;
  logic [CH-1:0]   out_valid;
  logic [CH-1:0]   out_ready = '0;
  logic            bad_sel;
`ifdef DEMUX_BROADCAST_EN
  logic            in_bcast  = 1'b0;
`endif

  demux_stream #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DEMUX_BROADCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bad_sel   (bad_sel)
  );

  // scoreboard: each channel is a capacity-one FIFO of accepted beats
  logic [W-1:0] exp_q [CH][$];
  logic [W-1:0] last_data [CH];
  logic         exp_bad  = 1'b0;
  logic         last_rdy = 1'b1;
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      exp_q[k].delete();
      last_data[k] = '0;
    end
    exp_bad = 1'b0;
  endtask

  task automatic check_outputs();
    logic [W-1:0] want;
    for (int k = 0; k < CH; k++) begin
      want = (exp_q[k].size() > 0) ? exp_q[k][0] : last_data[k];
      check_val($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(exp_q[k].size() > 0));
      check_val($sformatf("data%0d", k), 32'(out_data[k*W +: W]), 32'(want));
    end
    check_val("bad_sel", 32'(bad_sel), 32'(exp_bad));
  endtask

  // driver: one clock of stimulus, checked against the model
  task automatic cycle(input logic v, input logic [SW-1:0] sel,
                       input logic [W-1:0] d, input logic [CH-1:0] ordy);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (int'(sel) >= CH) exp_rdy = 1'b1;
    else                 exp_rdy = (exp_q[sel].size() == 0) || ordy[sel];
    check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
    last_rdy = exp_rdy;
    acc = v && exp_rdy;
    for (int k = 0; k < CH; k++)
      if (exp_q[k].size() > 0 && ordy[k]) void'(exp_q[k].pop_front());
    exp_bad = acc && (int'(sel) >= CH);
    if (acc && int'(sel) < CH) begin
      exp_q[sel].push_back(d);
      last_data[sel] = d;
    end
  endtask

  initial begin
    logic          v;
    logic [SW-1:0] s;
    logic [W-1:0]  d;

    model_reset();
    #3;
    check_val("rst_valid", 32'(out_valid), 32'(0));
    check_val("rst_data", 32'(out_data), 32'(0));
    check_val("rst_bad", 32'(bad_sel), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // basic routing
    cycle(1'b1, 2'd0, 4'hF, 3'b111);
    cycle(1'b1, 2'd1, 4'h3, 3'b111);
    cycle(1'b0, 2'd0, 4'h0, 3'b111);
    cycle(1'b0, 2'd0, 4'h0, 3'b111);

    // backpressure on channel 0
    cycle(1'b1, 2'd0, 4'hA, 3'b000);
    cycle(1'b1, 2'd0, 4'hB, 3'b000);
    cycle(1'b1, 2'd0, 4'hB, 3'b000);
    cycle(1'b1, 2'd0, 4'hB, 3'b001);
    cycle(1'b0, 2'd0, 4'h0, 3'b000);
    cycle(1'b0, 2'd0, 4'h0, 3'b111);

    // independence: ch0 stalled while ch1 streams
    cycle(1'b1, 2'd0, 4'h7, 3'b000);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 2'd1, 4'(i), 3'b010);
    cycle(1'b0, 2'd0, 4'h0, 3'b010);
    cycle(1'b0, 2'd0, 4'h0, 3'b111);

    // out-of-range select, single and back-to-back
    cycle(1'b1, 2'd3, 4'h5, 3'b000);
    cycle(1'b0, 2'd0, 4'h0, 3'b000);
    cycle(1'b1, 2'd3, 4'h6, 3'b000);
    cycle(1'b1, 2'd3, 4'h8, 3'b000);
    cycle(1'b0, 2'd0, 4'h0, 3'b111);
    cycle(1'b0, 2'd0, 4'h0, 3'b111);

    // asynchronous reset mid-cycle while ch1 holds a beat
    cycle(1'b1, 2'd1, 4'h9, 3'b000);
    cycle(1'b0, 2'd0, 4'h0, 3'b000);
    @(negedge clk);
    check_outputs();
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_valid", 32'(out_valid), 32'(0));
    check_val("arst_data", 32'(out_data), 32'(0));
    check_val("arst_bad", 32'(bad_sel), 32'(0));
    model_reset();
    in_valid  = 1'b0;
    out_ready = '1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, 4'h0, 3'b111);

    // randomized traffic honoring the producer hold rule
    for (int i = 0; i < 2000; i++) begin
      if (in_valid && !last_rdy) begin
        v = 1'b1;
        s = in_sel;
        d = in_data;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = 4'($urandom_range(0, 15));
      end
      cycle(v, s, d, 3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    check_outputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
